tlc_timer: RTL and testbench

- Timing source for the traffic light controller.
- Generates the `clk_en` tick that paces the controller FSM.
- Implements the countdown timer the controller drives through `timer_load`, `timer_en` and `timer_init`; returns `timer_out`.
- Sits directly beside the controller in the top level. The controller consumes `clk_en`, `timer_out` and `timer_expired`.

---
 rtl/tlc_pkg.sv | 16 +
 rtl/tlc_prescaler.sv | 33 +++
 rtl/tlc_timer.sv | 79 +++++++
 tb/tb_tlc_timer.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/tlc_pkg.sv
// Shared traffic-light-controller constants: timer state encodings and default timer width.
package tlc_pkg;

    localparam int unsigned TIMER_W_DEF = 4;
    localparam logic [TIMER_W_DEF-1:0] TIMER_MAX = '1;

    localparam logic [1:0] T_IDLE    = 2'd0;
    localparam logic [1:0] T_RUN     = 2'd1;
    localparam logic [1:0] T_EXPIRED = 2'd2;

    // Counter width for a divide-by-div prescaler; never below one bit.
    function automatic int unsigned cnt_width(input int unsigned div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

endpackage

// File: rtl/tlc_prescaler.sv
// Divides clk by CLK_DIV into a one-cycle registered clk_en tick; pause freezes the phase.
module tlc_prescaler
    import tlc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic pause,
    output logic clk_en
);

    localparam int unsigned        CNT_W    = cnt_width(CLK_DIV);
    localparam logic [CNT_W-1:0]   CNT_LAST = CNT_W'(CLK_DIV - 1);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count  <= '0;
            clk_en <= 1'b0;
        end else if (pause) begin
            clk_en <= 1'b0;
        end else if (count == CNT_LAST) begin
            count  <= '0;
            clk_en <= 1'b1;
        end else begin
            count  <= count + CNT_W'(1);
            clk_en <= 1'b0;
        end
    end

endmodule

// File: rtl/tlc_timer.sv
// Tick generator and saturating countdown timer for the traffic light controller.
// Optional freeze input enabled by defining TLC_TIMER_PAUSE_EN.
module tlc_timer
    import tlc_pkg::*;
#(
    parameter int unsigned CLK_DIV = 4,
    parameter int unsigned TIMER_W = TIMER_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
`ifdef TLC_TIMER_PAUSE_EN
    input  logic               pause,
`endif
    input  logic               timer_load,
    input  logic               timer_en,
    input  logic [TIMER_W-1:0] timer_init,
    output logic               clk_en,
    output logic [TIMER_W-1:0] timer_out,
    output logic               timer_expired
);

    logic               pause_i;
    logic               tick;
    logic [1:0]         state;
    logic [1:0]         state_nxt;
    logic [TIMER_W-1:0] out_nxt;
    logic               expired_nxt;

`ifdef TLC_TIMER_PAUSE_EN
    assign pause_i = pause;
`else
    assign pause_i = 1'b0;
`endif

    tlc_prescaler #(
        .CLK_DIV (CLK_DIV)
    ) u_prescaler (
        .clk    (clk),
        .rst    (rst),
        .pause  (pause_i),
        .clk_en (clk_en)
    );

    // A tick landing while paused is dropped so timer and state truly hold.
    assign tick = clk_en & ~pause_i;

    always_comb begin
        state_nxt   = state;
        out_nxt     = timer_out;
        expired_nxt = 1'b0;
        if (tick) begin
            if (timer_load) begin
                out_nxt   = timer_init;
                state_nxt = (timer_init != '0) ? T_RUN : T_EXPIRED;
            end else if (timer_en) begin
                if (timer_out > TIMER_W'(1)) begin
                    out_nxt = timer_out - TIMER_W'(1);
                end else if (timer_out == TIMER_W'(1)) begin
                    out_nxt     = '0;
                    state_nxt   = T_EXPIRED;
                    expired_nxt = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= T_IDLE;
            timer_out     <= '0;
            timer_expired <= 1'b0;
        end else begin
            state         <= state_nxt;
            timer_out     <= out_nxt;
            timer_expired <= expired_nxt;
        end
    end

endmodule

// File: tb/tb_tlc_timer.sv
// Directed self-checking bench for tlc_timer (CLK_DIV=4, TIMER_W=4).
module tb_tlc_timer;
    import tlc_pkg::*;

    logic       clk;
    logic       rst;
    logic       pause;
    logic       timer_load;
    logic       timer_en;
    logic [3:0] timer_init;
    logic       clk_en;
    logic [3:0] timer_out;
    logic       timer_expired;

    int checks   = 0;
    int failures = 0;

    tlc_timer #(
        .CLK_DIV (4),
        .TIMER_W (4)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef TLC_TIMER_PAUSE_EN
        .pause         (pause),
`endif
        .timer_load    (timer_load),
        .timer_en      (timer_en),
        .timer_init    (timer_init),
        .clk_en        (clk_en),
        .timer_out     (timer_out),
        .timer_expired (timer_expired)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Advance until the cycle in which clk_en is high (the next edge is a tick edge).
    task automatic wait_tick();
        int n;
        n = 0;
        do begin
            step();
            n++;
        end while (clk_en !== 1'b1 && n < 12);
        chk("tick_arrives", 32'(clk_en), 32'd1);
    endtask

    task automatic tick_step();
        wait_tick();
        step();
    endtask

    initial begin
        rst        = 1'b1;
        pause      = 1'b0;
        timer_load = 1'b0;
        timer_en   = 1'b0;
        timer_init = 4'd0;

        // 1. reset and prescaler phase
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst_clk_en", 32'(clk_en), 32'd0);
            chk("rst_out", 32'(timer_out), 32'd0);
            chk("rst_exp", 32'(timer_expired), 32'd0);
        end
        chk("rst_state", 32'(dut.state), 32'(T_IDLE));
        rst = 1'b0;
        for (int i = 1; i <= 12; i++) begin
            step();
            chk("presc_phase", 32'(clk_en), (i % 4 == 0) ? 32'd1 : 32'd0);
        end

        // 2. countdown 5..0 with single expiry pulse, then saturate
        timer_load = 1'b1;
        timer_init = 4'd5;
        step();
        chk("load5", 32'(timer_out), 32'd5);
        chk("load5_state", 32'(dut.state), 32'(T_RUN));
        timer_load = 1'b0;
        timer_en   = 1'b1;
        for (int v = 4; v >= 0; v--) begin
            tick_step();
            chk("count", 32'(timer_out), 32'(v));
            chk("count_exp", 32'(timer_expired), (v == 0) ? 32'd1 : 32'd0);
        end
        chk("exp_state", 32'(dut.state), 32'(T_EXPIRED));
        step();
        chk("exp_one_cycle", 32'(timer_expired), 32'd0);
        for (int i = 0; i < 2; i++) begin
            tick_step();
            chk("sat_out", 32'(timer_out), 32'd0);
            chk("sat_exp", 32'(timer_expired), 32'd0);
        end

        // 3. load priority over enable, max value, load of zero
        wait_tick();
        timer_load = 1'b1;
        timer_init = 4'd3;
        step();
        chk("load3", 32'(timer_out), 32'd3);
        wait_tick();
        timer_init = 4'd9;
        step();
        chk("load_over_en", 32'(timer_out), 32'd9);
        chk("load_over_en_state", 32'(dut.state), 32'(T_RUN));
        wait_tick();
        timer_init = TIMER_MAX;
        step();
        chk("load_max", 32'(timer_out), 32'd15);
        timer_load = 1'b0;
        tick_step();
        chk("dec_from_max", 32'(timer_out), 32'd14);
        wait_tick();
        timer_load = 1'b1;
        timer_init = 4'd0;
        step();
        chk("load0_out", 32'(timer_out), 32'd0);
        chk("load0_state", 32'(dut.state), 32'(T_EXPIRED));
        chk("load0_exp", 32'(timer_expired), 32'd0);

        // 4. hold with en=0, load toggles between ticks ignored
        wait_tick();
        timer_init = 4'd6;
        timer_en   = 1'b0;
        step();
        chk("load6", 32'(timer_out), 32'd6);
        timer_load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick_step();
            chk("hold6", 32'(timer_out), 32'd6);
        end
        timer_load = 1'b1;
        timer_init = 4'd2;
        step();
        timer_load = 1'b0;
        step();
        chk("offtick_load", 32'(timer_out), 32'd6);
        tick_step();
        chk("offtick_load_tick", 32'(timer_out), 32'd6);

        // 5. mid-operation reset
        wait_tick();
        timer_load = 1'b1;
        timer_init = 4'd7;
        step();
        timer_load = 1'b0;
        step();
        chk("pre_rst_out", 32'(timer_out), 32'd7);
        chk("pre_rst_count", 32'(dut.u_prescaler.count), 32'd2);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_out", 32'(timer_out), 32'd0);
        chk("mid_rst_clk_en", 32'(clk_en), 32'd0);
        chk("mid_rst_state", 32'(dut.state), 32'(T_IDLE));
        for (int i = 1; i <= 4; i++) begin
            step();
            chk("post_rst_phase", 32'(clk_en), (i == 4) ? 32'd1 : 32'd0);
        end

`ifdef TLC_TIMER_PAUSE_EN
        // 6. pause freezes prescaler phase and timer
        timer_load = 1'b1;
        timer_init = 4'd5;
        step();
        chk("p_load5", 32'(timer_out), 32'd5);
        timer_load = 1'b0;
        timer_en   = 1'b1;
        tick_step();
        chk("p_dec4", 32'(timer_out), 32'd4);
        step();
        pause = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step();
            chk("p_no_tick", 32'(clk_en), 32'd0);
        end
        chk("p_hold_out", 32'(timer_out), 32'd4);
        chk("p_hold_count", 32'(dut.u_prescaler.count), 32'd2);
        pause = 1'b0;
        step();
        chk("p_resume0", 32'(clk_en), 32'd0);
        step();
        chk("p_resume1", 32'(clk_en), 32'd1);
        step();
        chk("p_dec3", 32'(timer_out), 32'd3);
        tick_step();
        chk("p_dec2", 32'(timer_out), 32'd2);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
